// File: rtl/commit_trace_queue.sv
// Commit-trace buffer: accepts up to NCH in-order commits per cycle, retires one per cycle,
// keeps a shadow GPR file aligned with the retired record and reports a drained trap event.
module commit_trace_queue #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CODEW = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCH-1:0]            in_valid,
  input  logic [NCH*XLEN-1:0]       in_pc,
  input  logic [NCH*32-1:0]         in_instr,
  input  logic [NCH-1:0]            in_skip,
  input  logic [NCH-1:0]            in_wen,
  input  logic [NCH*5-1:0]          in_wdest,
  input  logic [NCH*XLEN-1:0]       in_wdata,
  output logic                      in_ready,
  input  logic                      halt_valid,
  input  logic [CODEW-1:0]          halt_code,
  input  logic [XLEN-1:0]           halt_pc,
  output logic                      out_valid,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_instr,
  output logic                      out_skip,
  output logic                      out_wen,
  output logic [4:0]                out_wdest,
  output logic [XLEN-1:0]           out_wdata,
  output logic [32*XLEN-1:0]        gpr,
  output logic [$clog2(DEPTH):0]    count,
  output logic [63:0]               cycle_cnt,
  output logic [63:0]               instr_cnt,
  output logic                      trap_valid,
  output logic [CODEW-1:0]          trap_code,
  output logic [XLEN-1:0]           trap_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            skip;
    logic            wen;
    logic [4:0]      wdest;
    logic [XLEN-1:0] wdata;
  } rec_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state;
  rec_t            mem [DEPTH];
  logic [XLEN-1:0] shadow [32];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  rec_t            hd;
  logic [NCH-1:0]  lane_en;
  logic [CW-1:0]   n_acc;
  logic [CW-1:0]   count_nxt;
  logic            pfx;
  logic            pop;

  assign hd        = mem[head];
  assign in_ready  = (state == RUN) && ((CW'(DEPTH) - count) >= CW'(NCH));
  assign out_valid = (count != '0) && (state != DONE);
  assign pop       = out_valid;
  assign count_nxt = count + n_acc - CW'(pop);

  assign out_pc    = out_valid ? hd.pc    : '0;
  assign out_instr = out_valid ? hd.instr : '0;
  assign out_skip  = out_valid & hd.skip;
  assign out_wen   = out_valid & hd.wen;
  assign out_wdest = out_valid ? hd.wdest : '0;
  assign out_wdata = out_valid ? hd.wdata : '0;

  // Only the contiguous valid prefix starting at lane 0 is accepted.
  always_comb begin
    lane_en = '0;
    n_acc   = '0;
    pfx     = in_ready;
    for (int i = 0; i < NCH; i++) begin
      pfx        = pfx & in_valid[i];
      lane_en[i] = pfx;
      n_acc      = n_acc + CW'(pfx);
    end
  end

  // Architectural view includes the write of the record being retired this cycle.
  always_comb begin
    gpr = '0;
    for (int r = 0; r < 32; r++) begin
      gpr[r*XLEN +: XLEN] = shadow[r];
      if (out_valid && hd.wen && (hd.wdest != 5'd0) && (hd.wdest == 5'(r)))
        gpr[r*XLEN +: XLEN] = hd.wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (lane_en[i]) begin
        mem[tail + PW'(i)] <= '{pc:    in_pc[i*XLEN +: XLEN],
                                instr: in_instr[i*32 +: 32],
                                skip:  in_skip[i],
                                wen:   in_wen[i],
                                wdest: in_wdest[i*5 +: 5],
                                wdata: in_wdata[i*XLEN +: XLEN]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      trap_valid <= 1'b0;
      trap_code  <= '0;
      trap_pc    <= '0;
      for (int r = 0; r < 32; r++) shadow[r] <= '0;
    end else begin
      tail       <= tail + PW'(n_acc);
      count      <= count_nxt;
      trap_valid <= 1'b0;
      if (state != DONE) cycle_cnt <= cycle_cnt + 64'd1;
      if (pop) begin
        head      <= head + PW'(1);
        instr_cnt <= instr_cnt + 64'd1;
        if (hd.wen && (hd.wdest != 5'd0)) shadow[hd.wdest] <= hd.wdata;
      end
      case (state)
        RUN: begin
          if (halt_valid) begin
            state     <= DRAIN;
            trap_code <= halt_code;
            trap_pc   <= halt_pc;
          end
        end
        DRAIN: begin
          if (count_nxt == '0) begin
            state      <= DONE;
            trap_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_queue.sv
// Bench for commit_trace_queue: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_commit_trace_queue;

  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 64;
  localparam int CODEW = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
  } rec_t;

  logic                 clk;
  logic                 reset;
  logic [NCH-1:0]       in_valid;
  logic [NCH*XLEN-1:0]  in_pc;
  logic [NCH*32-1:0]    in_instr;
  logic [NCH-1:0]       in_skip;
  logic [NCH-1:0]       in_wen;
  logic [NCH*5-1:0]     in_wdest;
  logic [NCH*XLEN-1:0]  in_wdata;
  logic                 in_ready;
  logic                 halt_valid;
  logic [CODEW-1:0]     halt_code;
  logic [XLEN-1:0]      halt_pc;
  logic                 out_valid;
  logic [XLEN-1:0]      out_pc;
  logic [31:0]          out_instr;
  logic                 out_skip;
  logic                 out_wen;
  logic [4:0]           out_wdest;
  logic [XLEN-1:0]      out_wdata;
  logic [32*XLEN-1:0]   gpr;
  logic [CW-1:0]        count;
  logic [63:0]          cycle_cnt;
  logic [63:0]          instr_cnt;
  logic                 trap_valid;
  logic [CODEW-1:0]     trap_code;
  logic [XLEN-1:0]      trap_pc;

  commit_trace_queue #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .CODEW(CODEW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_skip(in_skip),
    .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata), .in_ready(in_ready),
    .halt_valid(halt_valid), .halt_code(halt_code), .halt_pc(halt_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_skip(out_skip),
    .out_wen(out_wen), .out_wdest(out_wdest), .out_wdata(out_wdata),
    .gpr(gpr), .count(count), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
    .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of records plus architectural state.
  rec_t        mq[$];
  logic [63:0] m_gpr [32];
  int          m_st    = 0;
  logic [63:0] m_cyc   = '0;
  logic [63:0] m_icnt  = '0;
  logic        m_trapv = 1'b0;
  logic [2:0]  m_tcode = '0;
  logic [63:0] m_tpc   = '0;
  rec_t        m_r;
  logic        m_rdy, m_ov, m_go;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      for (int r = 0; r < 32; r++) m_gpr[r] = '0;
      m_st = 0; m_cyc = '0; m_icnt = '0; m_trapv = 1'b0; m_tcode = '0; m_tpc = '0;
    end else begin
      m_rdy = (m_st == 0) && ((DEPTH - mq.size()) >= NCH);
      m_ov  = (mq.size() != 0) && (m_st != 2);
      if (m_ov) begin
        m_r = mq.pop_front();
        if (m_r.wen && m_r.wdest != 5'd0) m_gpr[m_r.wdest] = m_r.wdata;
        m_icnt = m_icnt + 64'd1;
      end
      if (m_rdy) begin
        m_go = 1'b1;
        for (int i = 0; i < NCH; i++) begin
          if (m_go && in_valid[i]) begin
            m_r = '{pc: in_pc[i*XLEN +: XLEN], instr: in_instr[i*32 +: 32], skip: in_skip[i],
                    wen: in_wen[i], wdest: in_wdest[i*5 +: 5], wdata: in_wdata[i*XLEN +: XLEN]};
            mq.push_back(m_r);
          end else begin
            m_go = 1'b0;
          end
        end
      end
      if (m_st != 2) m_cyc = m_cyc + 64'd1;
      m_trapv = 1'b0;
      if (m_st == 0 && halt_valid) begin
        m_st = 1; m_tcode = halt_code; m_tpc = halt_pc;
      end else if (m_st == 1 && mq.size() == 0) begin
        m_st = 2; m_trapv = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  rec_t               c_h;
  logic               c_ev;
  logic [32*XLEN-1:0] c_eg;
  int                 c_bad;

  always @(negedge clk) begin
    if (chk_en) begin
      c_ev = (mq.size() != 0) && (m_st != 2);
      chk("in_ready", 64'(in_ready), 64'((m_st == 0) && ((DEPTH - mq.size()) >= NCH)));
      chk("out_valid", 64'(out_valid), 64'(c_ev));
      if (c_ev) begin
        c_h = mq[0];
        chk("out_pc", out_pc, c_h.pc);
        chk("out_instr", 64'(out_instr), 64'(c_h.instr));
        chk("out_skip", 64'(out_skip), 64'(c_h.skip));
        chk("out_wen", 64'(out_wen), 64'(c_h.wen));
        chk("out_wdest", 64'(out_wdest), 64'(c_h.wdest));
        chk("out_wdata", out_wdata, c_h.wdata);
      end
      chk("count", 64'(count), 64'(mq.size()));
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("instr_cnt", instr_cnt, m_icnt);
      chk("trap_valid", 64'(trap_valid), 64'(m_trapv));
      chk("trap_code", 64'(trap_code), 64'(m_tcode));
      chk("trap_pc", trap_pc, m_tpc);
      c_bad = -1;
      for (int r = 0; r < 32; r++) begin
        c_eg[r*XLEN +: XLEN] = m_gpr[r];
        if (c_ev && c_h.wen && c_h.wdest != 5'd0 && c_h.wdest == 5'(r))
          c_eg[r*XLEN +: XLEN] = c_h.wdata;
        if (c_bad < 0 && gpr[r*XLEN +: XLEN] !== c_eg[r*XLEN +: XLEN]) c_bad = r;
      end
      n_chk++;
      if (c_bad >= 0) begin
        n_fail++;
        $display("FAIL gpr[%0d]: actual=%h required=%h at %0t", c_bad,
                 gpr[c_bad*XLEN +: XLEN], c_eg[c_bad*XLEN +: XLEN], $time);
      end
    end
  end

  // Retired-pc trace and peak occupancy, for the streaming scenarios.
  logic [63:0] seen[$];
  int          max_cnt = 0;

  always @(negedge clk) begin
    if (chk_en && reset) begin
      if (out_valid) seen.push_back(out_pc);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  rec_t pend[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    in_valid = '0; in_pc = '0; in_instr = '0; in_skip = '0;
    in_wen = '0; in_wdest = '0; in_wdata = '0;
  endtask

  task automatic set_lane(input int i, input rec_t r);
    in_valid[i]             = 1'b1;
    in_pc[i*XLEN +: XLEN]   = r.pc;
    in_instr[i*32 +: 32]    = r.instr;
    in_skip[i]              = r.skip;
    in_wen[i]               = r.wen;
    in_wdest[i*5 +: 5]      = r.wdest;
    in_wdata[i*XLEN +: XLEN] = r.wdata;
  endtask

  function automatic rec_t mk(input logic [63:0] pc, input logic wen,
                              input logic [4:0] wd, input logic [63:0] data);
    rec_t r;
    r.pc = pc; r.instr = pc[31:0] ^ 32'h0000_0013; r.skip = pc[2];
    r.wen = wen; r.wdest = wd; r.wdata = data;
    return r;
  endfunction

  // Offer pending records up to 'lanes' per cycle, holding them while in_ready is low.
  task automatic pump(input int lanes);
    int   guard;
    int   n;
    bit   acc;
    rec_t tmp;
    guard = 0;
    while (pend.size() != 0 && guard < 200) begin
      clear_lanes();
      n = (pend.size() < lanes) ? pend.size() : lanes;
      for (int i = 0; i < n; i++) set_lane(i, pend[i]);
      acc = in_ready;
      tick();
      if (acc) for (int i = 0; i < n; i++) tmp = pend.pop_front();
      guard++;
    end
    if (pend.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL pump_timeout: actual=%0d pending required=0", pend.size());
      pend.delete();
    end
    clear_lanes();
  endtask

  task automatic wait_empty();
    int g;
    g = 0;
    while (count != '0 && g < 60) begin
      tick();
      g++;
    end
    chk("drain_timeout", 64'(count), 64'd0);
  endtask

  task automatic check_stream(input string nm, input logic [63:0] base, input int n);
    chk({nm, "_len"}, 64'(seen.size()), 64'(n));
    for (int k = 0; k < n && k < seen.size(); k++)
      chk({nm, "_order"}, seen[k], base + 64'(4 * k));
  endtask

  initial begin
    reset = 1'b0; halt_valid = 1'b0; halt_code = '0; halt_pc = '0;
    clear_lanes();
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cycle_cnt", cycle_cnt, 64'd0);
    chk("rst_instr_cnt", instr_cnt, 64'd0);
    chk("rst_trap_valid", 64'(trap_valid), 64'd0);
    reset = 1'b1;

    // Single lane-0 record becomes visible the cycle after enqueue.
    pend.push_back(mk(64'h8000_0000, 1'b1, 5'd1, 64'd5));
    pump(1);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_pc", out_pc, 64'h8000_0000);
    chk("t1_gpr1", gpr[1*XLEN +: XLEN], 64'd5);
    tick();
    chk("t1_instr_cnt", instr_cnt, 64'd1);
    chk("t1_gpr1_kept", gpr[1*XLEN +: XLEN], 64'd5);

    // Lane 1 without lane 0 is not a valid prefix.
    set_lane(1, mk(64'h8000_0040, 1'b1, 5'd2, 64'd7));
    in_valid = 2'b10;
    tick();
    clear_lanes();
    chk("t2_count", 64'(count), 64'd0);
    chk("t2_out_valid", 64'(out_valid), 64'd0);

    // Write to x0 keeps out_wen but never changes x0.
    pend.push_back(mk(64'h8000_0100, 1'b1, 5'd0, 64'hdead));
    pump(1);
    chk("t3_out_wen", 64'(out_wen), 64'd1);
    chk("t3_gpr0", gpr[0 +: XLEN], 64'd0);
    tick();
    chk("t3_gpr0_after", gpr[0 +: XLEN], 64'd0);

    // Two lanes every cycle, exercising in_ready back-pressure.
    seen.delete(); max_cnt = 0;
    for (int k = 0; k < 20; k++)
      pend.push_back(mk(64'h2000 + 64'(4 * k), k[0], 5'(k % 31 + 1), 64'(k * 3 + 1)));
    pump(2);
    wait_empty();
    check_stream("t4", 64'h2000, 20);
    chk("t4_max_count", 64'(max_cnt), 64'd7);

    // Paired burst then single-lane stream; pointers wrap several times.
    seen.delete(); max_cnt = 0;
    for (int k = 0; k < 8; k++)
      pend.push_back(mk(64'h3000 + 64'(4 * k), 1'b1, 5'(k + 8), 64'(100 + k)));
    pump(2);
    for (int k = 8; k < 20; k++)
      pend.push_back(mk(64'h3000 + 64'(4 * k), 1'b1, 5'(k + 8), 64'(100 + k)));
    pump(1);
    wait_empty();
    check_stream("t5", 64'h3000, 20);
    chk("t5_max_count", 64'(max_cnt), 64'd5);

    // Halt with three records outstanding, from a clean reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_lane(0, mk(64'h8000_0000, 1'b1, 5'd3, 64'h33));
    set_lane(1, mk(64'h8000_0004, 1'b0, 5'd0, 64'h0));
    tick();
    clear_lanes();
    set_lane(0, mk(64'h8000_0008, 1'b1, 5'd9, 64'h99));
    halt_valid = 1'b1; halt_code = 3'd1; halt_pc = 64'h8000_0010;
    tick();
    clear_lanes();
    halt_valid = 1'b0; halt_code = '0; halt_pc = '0;
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    chk("t6_trap_early", 64'(trap_valid), 64'd0);
    tick();
    tick();
    chk("t6_trap_valid", 64'(trap_valid), 64'd1);
    chk("t6_trap_code", 64'(trap_code), 64'd1);
    chk("t6_trap_pc", trap_pc, 64'h8000_0010);
    chk("t6_instr_cnt", instr_cnt, 64'd3);
    chk("t6_cycle_cnt", cycle_cnt, 64'd4);
    tick();
    chk("t6_trap_pulse", 64'(trap_valid), 64'd0);
    chk("t6_cycle_frozen", cycle_cnt, 64'd4);
    halt_valid = 1'b1; halt_code = 3'd5; halt_pc = 64'h1234;
    tick();
    halt_valid = 1'b0;
    chk("t6_code_held", 64'(trap_code), 64'd1);
    chk("t6_pc_held", trap_pc, 64'h8000_0010);

    // Reset while draining discards records and the pending trap.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_lane(0, mk(64'h4000, 1'b1, 5'd4, 64'h44));
    set_lane(1, mk(64'h4004, 1'b1, 5'd5, 64'h55));
    tick();
    set_lane(0, mk(64'h4008, 1'b1, 5'd6, 64'h66));
    set_lane(1, mk(64'h400c, 1'b1, 5'd7, 64'h77));
    halt_valid = 1'b1; halt_code = 3'd2; halt_pc = 64'h4100;
    tick();
    clear_lanes();
    halt_valid = 1'b0;
    tick();
    chk("t7_count_pre", 64'(count), 64'd2);
    chk("t7_gpr5_pre", gpr[5*XLEN +: XLEN], 64'h55);
    reset = 1'b0;
    tick();
    chk("t7_count", 64'(count), 64'd0);
    chk("t7_out_valid", 64'(out_valid), 64'd0);
    chk("t7_trap_valid", 64'(trap_valid), 64'd0);
    chk("t7_gpr_zero", 64'(gpr != '0), 64'd0);
    tick();
    chk("t7_trap_valid_hold", 64'(trap_valid), 64'd0);
    reset = 1'b1;
    tick();
    chk("t7_trap_after", 64'(trap_valid), 64'd0);
    chk("t7_out_after", 64'(out_valid), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/commit_trace_queue.md
Name: commit_trace_queue

Overview:
- Parametrised commit-trace buffer between a multi-issue core's writeback stage and the difftest/trace observers.
- Accepts up to NCH in-order commit records per cycle and retires exactly one per cycle to a single-commit observer port.
- Keeps a shadow GPR file aligned with the retired record, so register state never lags the commit by a cycle.
- Counts cycles and retired instructions, and raises a trap event only after all outstanding commits have drained.

Parameters:
- NCH, 2, commit lanes accepted per cycle (1..4).
- DEPTH, 8, queue entries; power of 2, DEPTH >= 2*NCH.
- XLEN, 64, data/pc width.
- CODEW, 3, trap code width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge).
- in_valid  in  NCH  per-lane commit valid; lane 0 is oldest.
- in_pc  in  NCH*XLEN  lane pc.
- in_instr  in  NCH*32  lane instruction.
- in_skip  in  NCH  lane difftest skip flag.
- in_wen  in  NCH  lane GPR write enable.
- in_wdest  in  NCH*5  lane destination register.
- in_wdata  in  NCH*XLEN  lane write data.
- in_ready  out  1  queue accepts this cycle.
- halt_valid  in  1  halt request.
- halt_code  in  CODEW  halt code.
- halt_pc  in  XLEN  halt pc.
- out_valid  out  1  retired record valid.
- out_pc, out_instr, out_skip, out_wen, out_wdest, out_wdata  out  XLEN,32,1,1,5,XLEN  retired record fields.
- gpr  out  32*XLEN  shadow GPRs including the current out record's write.
- count  out  clog2(DEPTH)+1  occupied entries.
- cycle_cnt  out  64  cycle counter.
- instr_cnt  out  64  retired-record counter.
- trap_valid  out  1  trap event pulse.
- trap_code  out  CODEW  latched halt code.
- trap_pc  out  XLEN  latched halt pc.

Behaviour:
- Reset: every output 0; count=0; head=tail=0; shadow GPRs 0; counters 0; state RUN.
- Reset asserted mid-operation discards all queued records and any pending trap; trap_valid stays 0.
- States:
  - RUN to DRAIN on halt_valid; halt_code and halt_pc are latched on that edge.
  - DRAIN to DONE when count==0 after a pop (or immediately if count==0 on entry).
  - DONE is held until reset.
- in_ready = (state==RUN) && (DEPTH - count >= NCH).
- Accepted lanes:
  - Only the contiguous prefix of valid lanes starting at lane 0 is accepted; lanes after the first invalid lane are ignored.
  - Accepted lanes are written at tail, tail+1, ... in lane order.
  - When in_ready=0, inputs are ignored and the producer must hold them.
- Simultaneous halt_valid and enqueue: that cycle's records are accepted first, then DRAIN is entered.
- Storage is registered: a record enqueued at edge t is visible on out_* no earlier than cycle t+1.
- Retire:
  - out_valid = (count!=0) && state!=DONE.
  - out_* come from the head entry.
  - Pop occurs every out_valid cycle; there is no output backpressure.
- Simultaneous enqueue and pop: count += accepted - popped.
- Pointers wrap modulo DEPTH.
- Shadow GPRs:
  - gpr is combinational: the registered shadow with the head write applied when out_valid && out_wen && out_wdest!=0.
  - The registered shadow commits that write on the pop edge.
  - x0 always reads 0.
  - out_wen passes through unmodified, even for x0.
- Counters:
  - cycle_cnt increments each cycle while state!=DONE, then freezes.
  - instr_cnt increments per pop; skipped records are counted too.
- Trap:
  - trap_valid is registered, high for exactly one cycle: the cycle after the DRAIN-to-DONE transition edge.
  - trap_code and trap_pc hold their latched values from DRAIN entry until reset.
- halt_valid outside RUN is ignored.

Test Plan:
- NCH=2, DEPTH=8: lane0 only, pc=0x80000000, wen=1, wdest=1, wdata=5 -> next cycle out_valid=1, out_pc=0x80000000, gpr[1]=5 in that cycle; instr_cnt=1 the cycle after.
- Both lanes valid every cycle with in_valid held when in_ready=0 -> pcs emerge strictly ordered, one per cycle, none lost or duplicated.
- in_valid=2'b10 -> nothing enqueued, count unchanged.
- wen=1, wdest=0, wdata=0xdead -> out_wen=1, gpr[0]=0 throughout.
- Stream 20 single-lane records through DEPTH=8 with an initial burst that forces wrap -> out_pc sequence matches input order exactly; count never exceeds 8.
- 3 records queued, then halt_valid with code=1, pc=0x80000010 -> in_ready=0; 3 pops; trap_valid=1 for one cycle with trap_code=1 and trap_pc=0x80000010; cycle_cnt frozen, instr_cnt=3.
- reset=0 during DRAIN with 2 records queued -> next cycle count=0, out_valid=0, trap_valid stays 0, gpr all 0.
